// File: rtl/mem_arbiter.sv
// mem_arbiter: three-port round-robin arbiter in front of a single-ported
// synchronous word memory. Port 0 = instruction fetch, 1 = load/store,
// 2 = UART loader.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pN_req/we/wmask/addr/wdata  requester N transaction (held until pN_gnt)
//   pN_gnt                   combinational grant for requester N
//   pN_done                  completion pulse one cycle after the grant
//   rdata                    read data, valid while some pN_done is high
//   mem_en/addr/wmask/wdata  memory command port
//   mem_rdata                memory read data, valid the cycle after mem_en
module mem_arbiter #(
   parameter int unsigned AW = 8
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [3:0]    p0_wmask,
   input  logic [AW-1:0] p0_addr,
   input  logic [31:0]   p0_wdata,
   output logic          p0_gnt,
   output logic          p0_done,

   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [3:0]    p1_wmask,
   input  logic [AW-1:0] p1_addr,
   input  logic [31:0]   p1_wdata,
   output logic          p1_gnt,
   output logic          p1_done,

   input  logic          p2_req,
   input  logic          p2_we,
   input  logic [3:0]    p2_wmask,
   input  logic [AW-1:0] p2_addr,
   input  logic [31:0]   p2_wdata,
   output logic          p2_gnt,
   output logic          p2_done,

   output logic [31:0]   rdata,

   output logic          mem_en,
   output logic [AW-1:0] mem_addr,
   output logic [3:0]    mem_wmask,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   localparam int unsigned NP = 3;

   logic [1:0]    last_q, last_d;
   logic          inf_valid_q, inf_valid_d;
   logic [1:0]    inf_port_q, inf_port_d;

   logic [3:0]    req4;
   logic [1:0]    win;
   logic          any_req;
   logic          any_gnt;
   logic [NP-1:0] gnt_vec;
   logic [NP-1:0] done_vec;

   assign req4 = {1'b0, p2_req, p1_req, p0_req};

   // Round-robin pick: scan from the port after last, wrapping 2 -> 0.
   // The loop runs lowest priority first so the last hit wins.
   always_comb begin
      logic [2:0] idx;
      win     = 2'd0;
      any_req = 1'b0;
      idx     = 3'd0;
      for (int off = 3; off >= 1; off--) begin
         idx = 3'({1'b0, last_q}) + 3'(off);
         if (idx >= 3'd3) idx = idx - 3'd3;
         if (req4[idx[1:0]]) begin
            win     = idx[1:0];
            any_req = 1'b1;
         end
      end
   end

   // No grants while reset is held.
   assign any_gnt = any_req && !rst;

   always_comb begin
      gnt_vec = '0;
      if (any_gnt) gnt_vec = NP'(3'b001 << win);
   end

   assign p0_gnt = gnt_vec[0];
   assign p1_gnt = gnt_vec[1];
   assign p2_gnt = gnt_vec[2];

   // Memory command mux from the winner; idle port drives zeros.
   always_comb begin
      mem_en    = any_gnt;
      mem_addr  = '0;
      mem_wmask = 4'b0000;
      mem_wdata = 32'h0;
      if (any_gnt) begin
         case (win)
            2'd0: begin
               mem_addr  = p0_addr;
               mem_wmask = p0_we ? p0_wmask : 4'b0000;
               mem_wdata = p0_wdata;
            end
            2'd1: begin
               mem_addr  = p1_addr;
               mem_wmask = p1_we ? p1_wmask : 4'b0000;
               mem_wdata = p1_wdata;
            end
            default: begin
               mem_addr  = p2_addr;
               mem_wmask = p2_we ? p2_wmask : 4'b0000;
               mem_wdata = p2_wdata;
            end
         endcase
      end
   end

   // Next-state for the priority pointer and the in-flight slot.
   always_comb begin
      last_d      = last_q;
      inf_valid_d = any_gnt;
      inf_port_d  = inf_port_q;
      if (any_gnt) begin
         last_d     = win;
         inf_port_d = win;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q      <= 2'd2;
         inf_valid_q <= 1'b0;
         inf_port_q  <= 2'd0;
      end else begin
         last_q      <= last_d;
         inf_valid_q <= inf_valid_d;
         inf_port_q  <= inf_port_d;
      end
   end

   // Completion decoded from the in-flight flops; a reset in the cycle
   // after the grant kills the pending completion.
   always_comb begin
      done_vec = '0;
      if (inf_valid_q && !rst) done_vec = NP'(3'b001 << inf_port_q);
   end

   assign p0_done = done_vec[0];
   assign p1_done = done_vec[1];
   assign p2_done = done_vec[2];

   assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x32 synchronous RAM.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p0_we, p1_req, p1_we, p2_req, p2_we;
   logic [3:0]  p0_wmask, p1_wmask, p2_wmask;
   logic [7:0]  p0_addr, p1_addr, p2_addr;
   logic [31:0] p0_wdata, p1_wdata, p2_wdata;
   logic        p0_gnt, p1_gnt, p2_gnt, p0_done, p1_done, p2_done;
   logic [31:0] rdata;
   logic        mem_en;
   logic [7:0]  mem_addr;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic        mem_init;
   logic [31:0] mem [256];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(8)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_wmask(p0_wmask), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
      .p1_req(p1_req), .p1_we(p1_we), .p1_wmask(p1_wmask), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
      .p2_req(p2_req), .p2_we(p2_we), .p2_wmask(p2_wmask), .p2_addr(p2_addr),
      .p2_wdata(p2_wdata), .p2_gnt(p2_gnt), .p2_done(p2_done),
      .rdata(rdata),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Synchronous RAM: read returns old contents, byte-masked write.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
         mem[5] <= 32'hDEAD_BEEF;
         mem[7] <= 32'h1122_3344;
      end else if (mem_en) begin
         mem_rdata <= mem[mem_addr];
         for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [2:0]  we;
      logic [3:0]  wmask;
      logic [7:0]  a0, a1, a2;
      logic [31:0] wdata;
      logic [2:0]  e_gnt;
      logic [2:0]  e_done;
      logic        e_en;
      logic [7:0]  e_addr;
      logic [3:0]  e_wmask;
      logic [31:0] e_wdata;
      logic        chk_rd;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic [2:0] req, input logic [2:0] we,
                               input logic [3:0] wm, input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] a2, input logic [31:0] wd,
                               input logic [2:0] eg, input logic [2:0] ed, input logic een,
                               input logic [7:0] ea, input logic [3:0] ewm,
                               input logic crd, input logic [31:0] erd);
      vec_t v;
      v.rst = r; v.req = req; v.we = we; v.wmask = wm;
      v.a0 = a0; v.a1 = a1; v.a2 = a2; v.wdata = wd;
      v.e_gnt = eg; v.e_done = ed; v.e_en = een; v.e_addr = ea; v.e_wmask = ewm;
      v.e_wdata = wd; v.chk_rd = crd; v.e_rdata = erd;
      return v;
   endfunction

   function automatic vec_t idle(input logic [2:0] ed, input logic crd, input logic [31:0] erd);
      return mk(1'b0, 3'b000, 3'b000, 4'h0, 8'd0, 8'd0, 8'd0, 32'h0,
                3'b000, ed, 1'b0, 8'd0, 4'h0, crd, erd);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst;
      {p2_req, p1_req, p0_req} = v.req;
      {p2_we, p1_we, p0_we}    = v.we;
      p0_wmask = v.wmask; p1_wmask = v.wmask; p2_wmask = v.wmask;
      p0_wdata = v.wdata; p1_wdata = v.wdata; p2_wdata = v.wdata;
      p0_addr = v.a0; p1_addr = v.a1; p2_addr = v.a2;
   endtask

   function automatic logic [2:0] gnts();
      return {p2_gnt, p1_gnt, p0_gnt};
   endfunction

   function automatic logic [2:0] dones();
      return {p2_done, p1_done, p0_done};
   endfunction

   logic [31:0] b2b_exp [8];

   initial begin
      vec_t v;
      logic [2:0] exp_g;
      int waited;
      bit got;

      drive(idle(3'b000, 1'b0, 32'h0));
      rst = 1'b1;
      mem_init = 1'b1;
      @(posedge clk);
      #1 mem_init = 1'b0;

      b2b_exp = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                  32'hA000_0004, 32'hDEAD_BEEF, 32'hA000_0006, 32'h11BB_33DD};

      // reset with requests present, then single read of word 5
      vecs.push_back(mk(1, 3'b111, 3'b000, 4'h0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3'b000, 3'b000, 4'h0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0));
      vecs.push_back(idle(3'b000, 0, 0));
      vecs.push_back(mk(0, 3'b001, 3'b000, 4'h0, 5, 0, 0, 0, 3'b001, 3'b000, 1, 5, 0, 0, 0));
      vecs.push_back(idle(3'b001, 1, 32'hDEAD_BEEF));
      // three-way contention right after reset
      vecs.push_back(mk(1, 3'b000, 3'b000, 4'h0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'b111, 3'b000, 4'h0, 0, 1, 2, 0, 3'b001, 3'b000, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'b111, 3'b000, 4'h0, 0, 1, 2, 0, 3'b010, 3'b001, 1, 1, 0, 1, 32'hA000_0000));
      vecs.push_back(mk(0, 3'b111, 3'b000, 4'h0, 0, 1, 2, 0, 3'b100, 3'b010, 1, 2, 0, 1, 32'hA000_0001));
      vecs.push_back(mk(0, 3'b111, 3'b000, 4'h0, 0, 1, 2, 0, 3'b001, 3'b100, 1, 0, 0, 1, 32'hA000_0002));
      vecs.push_back(mk(0, 3'b111, 3'b000, 4'h0, 0, 1, 2, 0, 3'b010, 3'b001, 1, 1, 0, 1, 32'hA000_0000));
      vecs.push_back(mk(0, 3'b111, 3'b000, 4'h0, 0, 1, 2, 0, 3'b100, 3'b010, 1, 2, 0, 1, 32'hA000_0001));
      vecs.push_back(idle(3'b100, 1, 32'hA000_0002));
      // byte-masked write then read of word 7
      vecs.push_back(mk(0, 3'b010, 3'b010, 4'b0101, 0, 7, 0, 32'hAABB_CCDD, 3'b010, 3'b000, 1, 7, 4'b0101, 0, 0));
      vecs.push_back(mk(0, 3'b010, 3'b000, 4'b0101, 0, 7, 0, 0, 3'b010, 3'b010, 1, 7, 4'b0000, 0, 0));
      vecs.push_back(idle(3'b010, 1, 32'h11BB_33DD));
      // back-to-back reads from p2, addresses 0..7
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(0, 3'b100, 3'b000, 4'h0, 0, 0, 8'(i), 0, 3'b100,
                           (i > 0) ? 3'b100 : 3'b000, 1, 8'(i), 0, i > 0,
                           (i > 0) ? b2b_exp[(i > 0) ? i - 1 : 0] : 32'h0));
      vecs.push_back(idle(3'b100, 1, 32'h11BB_33DD));
      // reset in the cycle after a grant, then p0 wins over p1
      vecs.push_back(mk(0, 3'b001, 3'b000, 4'h0, 5, 0, 0, 0, 3'b001, 3'b000, 1, 5, 0, 0, 0));
      vecs.push_back(mk(1, 3'b000, 3'b000, 4'h0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'b011, 3'b000, 4'h0, 3, 4, 0, 0, 3'b001, 3'b000, 1, 3, 0, 0, 0));
      vecs.push_back(mk(0, 3'b010, 3'b000, 4'h0, 0, 4, 0, 0, 3'b010, 3'b001, 1, 4, 0, 1, 32'hA000_0003));
      vecs.push_back(idle(3'b010, 1, 32'hA000_0004));
      // p1 write request dropped while p0 holds the port
      vecs.push_back(mk(0, 3'b011, 3'b010, 4'hF, 1, 6, 0, 32'hFFFF_FFFF, 3'b001, 3'b000, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 3'b001, 3'b000, 4'h0, 2, 0, 0, 0, 3'b001, 3'b001, 1, 2, 0, 1, 32'hA000_0001));
      vecs.push_back(idle(3'b001, 1, 32'hA000_0002));
      // p2 mask-0 write to word 6, read back unchanged
      vecs.push_back(mk(0, 3'b100, 3'b100, 4'h0, 0, 0, 6, 32'h1234_5678, 3'b100, 3'b000, 1, 6, 4'h0, 0, 0));
      vecs.push_back(mk(0, 3'b100, 3'b000, 4'h0, 0, 0, 6, 0, 3'b100, 3'b100, 1, 6, 4'h0, 0, 0));
      vecs.push_back(idle(3'b100, 1, 32'hA000_0006));

      foreach (vecs[n]) begin
         v = vecs[n];
         @(negedge clk);
         drive(v);
         #1;
         chk($sformatf("v%0d gnt", n), 32'(gnts()), 32'(v.e_gnt));
         chk($sformatf("v%0d done", n), 32'(dones()), 32'(v.e_done));
         chk($sformatf("v%0d mem_en", n), 32'(mem_en), 32'(v.e_en));
         if (v.e_en) begin
            chk($sformatf("v%0d mem_addr", n), 32'(mem_addr), 32'(v.e_addr));
            chk($sformatf("v%0d mem_wmask", n), 32'(mem_wmask), 32'(v.e_wmask));
            if (v.e_wmask != 4'h0)
               chk($sformatf("v%0d mem_wdata", n), mem_wdata, v.e_wdata);
         end
         if (v.chk_rd) chk($sformatf("v%0d rdata", n), rdata, v.e_rdata);
      end

      // sustained three-way contention from last=2: 0,1,2,0,1,2
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         drive(mk(0, 3'b111, 3'b000, 4'h0, 10, 11, 12, 0, 0, 0, 0, 0, 0, 0, 0));
         #1;
         exp_g = 3'(3'b001 << (c % 3));
         chk($sformatf("rr c%0d gnt", c), 32'(gnts()), 32'(exp_g));
         if (c > 0) chk($sformatf("rr c%0d done", c), 32'(dones()), 32'(3'(3'b001 << ((c + 2) % 3))));
      end
      @(negedge clk);
      drive(idle(3'b000, 0, 0));
      #1 chk("rr tail done", 32'(dones()), 32'(3'b100));

      // p1 alone: bounded wait for grant, then done + data next cycle
      got = 1'b0;
      waited = 0;
      while (!got && waited < 4) begin
         @(negedge clk);
         drive(mk(0, 3'b010, 3'b000, 4'h0, 0, 8'd11, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         #1;
         got = p1_gnt;
         waited++;
      end
      chk("p1 grant within bound", 32'(got), 32'd1);
      chk("p1 grant latency", 32'(waited), 32'd1);
      @(negedge clk);
      drive(idle(3'b000, 0, 0));
      #1;
      chk("p1 done", 32'(dones()), 32'(3'b010));
      chk("p1 rdata", rdata, 32'hA000_000B);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
